// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave backed by a word-addressed RAM with byte strobes.
// Read and write channels run independently; reads see pre-write data.
module axi_lite_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [31:0] ARdata,
  input  logic [2:0]  arprot,
  output logic        Rvalid,
  input  logic        Rready,
  output logic [31:0] Rdata,
  output logic [1:0]  Rresp,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [31:0] AWdata,
  input  logic [2:0]  awprot,
  input  logic        Wvalid,
  output logic        Wready,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  output logic        Bvalid,
  input  logic        Bready,
  output logic [1:0]  Bresp
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic {W_COLLECT, W_RESP} w_state_e;

  logic [31:0] mem_q [DEPTH];

  r_state_e    r_state_q, r_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [1:0]  bresp_q, bresp_d;

  logic                  ar_hs, aw_hs, w_hs;
  logic                  ar_hit, wr_hit;
  logic [DEPTH_LOG2-1:0] ar_idx, wr_idx;
  logic [31:0]           wr_addr, wr_data;
  logic [3:0]            wr_strb;
  logic                  commit, mem_we;
  logic                  unused_bits;

  function automatic logic in_window(input logic [31:0] a);
    return a[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2];
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (wr_strb[n]) mem_q[wr_idx][8*n +: 8] <= wr_data[8*n +: 8];
      end
    end
  end

  // Output / ready logic
  always_comb begin
    ARready = resetn && (r_state_q == R_IDLE);
    AWready = resetn && (w_state_q == W_COLLECT) && !aw_held_q;
    Wready  = resetn && (w_state_q == W_COLLECT) && !w_held_q;
    Rvalid  = (r_state_q == R_RESP);
    Rdata   = rdata_q;
    Rresp   = rresp_q;
    Bvalid  = (w_state_q == W_RESP);
    Bresp   = bresp_q;
  end

  always_comb begin
    ar_hs   = ARvalid && ARready;
    aw_hs   = AWvalid && AWready;
    w_hs    = Wvalid && Wready;
    ar_hit  = in_window(ARdata);
    ar_idx  = ARdata[DEPTH_LOG2+1:2];
    wr_addr = aw_held_q ? aw_addr_q : AWdata;
    wr_data = w_held_q ? w_data_q : Wdata;
    wr_strb = w_held_q ? w_strb_q : Wstrb;
    wr_hit  = in_window(wr_addr);
    wr_idx  = wr_addr[DEPTH_LOG2+1:2];
    commit  = (w_state_q == W_COLLECT)
              && (aw_held_q || aw_hs)
              && (w_held_q || w_hs);
    mem_we  = commit && wr_hit;
  end

  // Read next-state
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          rdata_d   = ar_hit ? mem_q[ar_idx] : '0;
          rresp_d   = ar_hit ? OKAY : SLVERR;
        end
      end
      R_RESP: begin
        if (Rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write next-state
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_COLLECT: begin
        if (commit) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = wr_hit ? OKAY : SLVERR;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = AWdata;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = Wdata;
            w_strb_d = Wstrb;
          end
        end
      end
      W_RESP: begin
        if (Bready) w_state_d = W_COLLECT;
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  assign unused_bits = ^{arprot, awprot, ARdata[1:0], wr_addr[1:0]};

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Bench for axi_lite_mem_responder: transaction model plus directed vectors.
// Model compares every cycle; directed tasks pin literal values.
module tb_axi_lite_mem_responder;

  localparam int          DL2  = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ARvalid, ARready;
  logic [31:0] ARdata;
  logic [2:0]  arprot;
  logic        Rvalid, Rready;
  logic [31:0] Rdata;
  logic [1:0]  Rresp;
  logic        AWvalid, AWready;
  logic [31:0] AWdata;
  logic [2:0]  awprot;
  logic        Wvalid, Wready;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Bvalid, Bready;
  logic [1:0]  Bresp;

  int nvec  = 0;
  int nfail = 0;
  bit started = 0;

  axi_lite_mem_responder #(
    .DEPTH_LOG2(DL2),
    .BASE_ADDR (BASE)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .ARvalid(ARvalid),
    .ARready(ARready),
    .ARdata (ARdata),
    .arprot (arprot),
    .Rvalid (Rvalid),
    .Rready (Rready),
    .Rdata  (Rdata),
    .Rresp  (Rresp),
    .AWvalid(AWvalid),
    .AWready(AWready),
    .AWdata (AWdata),
    .awprot (awprot),
    .Wvalid (Wvalid),
    .Wready (Wready),
    .Wdata  (Wdata),
    .Wstrb  (Wstrb),
    .Bvalid (Bvalid),
    .Bready (Bready),
    .Bresp  (Bresp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: a word array plus pending-response flags
  logic [31:0] mm [0:1023];
  bit          m_rv, m_bv, m_aw, m_w;
  logic [31:0] m_rdata, m_awaddr, m_wdata;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  function automatic bit hit(input logic [31:0] a);
    return (a >> (DL2 + 2)) == (BASE >> (DL2 + 2));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << DL2));
  endfunction

  always @(posedge clock) begin : model
    bit ar_f, aw_f, w_f;
    if (!resetn) begin
      m_rv = 0; m_bv = 0; m_aw = 0; m_w = 0;
      m_rdata = 0; m_rresp = 0; m_bresp = 0;
    end else begin
      ar_f = ARvalid && !m_rv;
      aw_f = AWvalid && !m_bv && !m_aw;
      w_f  = Wvalid && !m_bv && !m_w;
      if (m_rv) begin
        if (Rready) m_rv = 0;
      end else if (ar_f) begin
        m_rv    = 1;
        m_rdata = hit(ARdata) ? mm[widx(ARdata)] : 32'h0;
        m_rresp = hit(ARdata) ? 2'b00 : 2'b10;
      end
      if (m_bv) begin
        if (Bready) m_bv = 0;
      end else begin
        if (aw_f) begin m_aw = 1; m_awaddr = AWdata; end
        if (w_f) begin m_w = 1; m_wdata = Wdata; m_wstrb = Wstrb; end
        if (m_aw && m_w) begin
          if (hit(m_awaddr))
            for (int n = 0; n < 4; n++)
              if (m_wstrb[n])
                mm[widx(m_awaddr)][8*n +: 8] = m_wdata[8*n +: 8];
          m_bresp = hit(m_awaddr) ? 2'b00 : 2'b10;
          m_bv = 1; m_aw = 0; m_w = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("m_arready", ARready, resetn && !m_rv);
      chk("m_awready", AWready, resetn && !m_bv && !m_aw);
      chk("m_wready",  Wready,  resetn && !m_bv && !m_w);
      chk("m_rvalid",  Rvalid,  m_rv);
      chk("m_bvalid",  Bvalid,  m_bv);
      chk("m_rdata",   Rdata,   m_rdata);
      chk("m_rresp",   Rresp,   m_rresp);
      chk("m_bresp",   Bresp,   m_bresp);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                    input logic [1:0] er, input int hold);
    ARvalid = 1; ARdata = a;
    tick();
    ARvalid = 0;
    chk("rd_rvalid", Rvalid, 1);
    chk("rd_rdata", Rdata, ed);
    chk("rd_rresp", Rresp, er);
    repeat (hold) begin
      tick();
      chk("rd_hold_rvalid", Rvalid, 1);
      chk("rd_hold_rdata", Rdata, ed);
      chk("rd_hold_arready", ARready, 0);
    end
    Rready = 1;
    tick();
    Rready = 0;
    chk("rd_rdrop", Rvalid, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int awd, input int wd,
                    input logic [1:0] er, input int hold);
    int last;
    last = (awd > wd) ? awd : wd;
    for (int c = 0; c <= last; c++) begin
      AWvalid = (c == awd); AWdata = a;
      Wvalid  = (c == wd);  Wdata = d; Wstrb = s;
      if (c > wd) chk("wr_wready_low", Wready, 0);
      if (c > awd) chk("wr_awready_low", AWready, 0);
      chk("wr_no_early_b", Bvalid, 0);
      tick();
    end
    AWvalid = 0; Wvalid = 0;
    chk("wr_bvalid", Bvalid, 1);
    chk("wr_bresp", Bresp, er);
    repeat (hold) begin
      tick();
      chk("wr_hold_bvalid", Bvalid, 1);
      chk("wr_hold_bresp", Bresp, er);
      chk("wr_hold_awready", AWready, 0);
      chk("wr_hold_wready", Wready, 0);
    end
    Bready = 1;
    tick();
    Bready = 0;
    chk("wr_bdrop", Bvalid, 0);
  endtask

  initial begin
    resetn = 0; ARvalid = 0; ARdata = 0; arprot = 0; Rready = 0;
    AWvalid = 0; AWdata = 0; awprot = 3'b111; Wvalid = 0; Wdata = 0;
    Wstrb = 0; Bready = 0;
    tick();
    started = 1;
    tick();
    chk("rst_rvalid", Rvalid, 0);
    chk("rst_bvalid", Bvalid, 0);
    chk("rst_rdata", Rdata, 0);
    chk("rst_rresp", Rresp, 0);
    chk("rst_bresp", Bresp, 0);
    chk("rst_arready", ARready, 0);
    chk("rst_awready", AWready, 0);
    resetn = 1;
    #1;
    chk("rel_arready", ARready, 1);
    chk("rel_awready", AWready, 1);
    chk("rel_wready", Wready, 1);
    tick();

    wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 0);
    rd(32'h10, 32'hDEADBEEF, 2'b00, 0);

    wr(32'h20, 32'h11223344, 4'hF, 0, 0, 2'b00, 0);
    wr(32'h20, 32'hAAAAAAAA, 4'b0100, 0, 0, 2'b00, 0);
    rd(32'h20, 32'h11AA3344, 2'b00, 0);

    wr(32'h24, 32'hCAFEF00D, 4'hF, 3, 0, 2'b00, 0);
    rd(32'h24, 32'hCAFEF00D, 2'b00, 0);

    wr(32'h28, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 0);
    wr(32'h28, 32'h12345678, 4'b0011, 0, 2, 2'b00, 0);
    rd(32'h28, 32'hFFFF5678, 2'b00, 0);

    rd(32'h10, 32'hDEADBEEF, 2'b00, 5);
    wr(32'h2C, 32'h0BADCAFE, 4'hF, 0, 0, 2'b00, 5);
    rd(32'h2C, 32'h0BADCAFE, 2'b00, 0);

    wr(32'h20, 32'h00000000, 4'b0000, 0, 0, 2'b00, 0);
    rd(32'h20, 32'h11AA3344, 2'b00, 0);

    rd(32'h1010, 32'h0, 2'b10, 0);
    wr(32'h1010, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 0);
    wr(32'h8000_0010, 32'h00000000, 4'hF, 1, 0, 2'b10, 0);
    rd(32'h10, 32'hDEADBEEF, 2'b00, 0);
    rd(32'h13, 32'hDEADBEEF, 2'b00, 0);

    wr(32'h30, 32'h01020304, 4'hF, 0, 0, 2'b00, 0);
    ARvalid = 1; ARdata = 32'h30;
    AWvalid = 1; AWdata = 32'h30;
    Wvalid = 1; Wdata = 32'h55667788; Wstrb = 4'hF;
    tick();
    ARvalid = 0; AWvalid = 0; Wvalid = 0;
    chk("rf_rdata", Rdata, 32'h01020304);
    chk("rf_bvalid", Bvalid, 1);
    Rready = 1; Bready = 1;
    tick();
    Rready = 0; Bready = 0;
    rd(32'h30, 32'h55667788, 2'b00, 0);

    ARvalid = 1; ARdata = 32'h10;
    AWvalid = 1; AWdata = 32'h34;
    Wvalid = 1; Wdata = 32'h77777777; Wstrb = 4'hF;
    tick();
    ARvalid = 0; AWvalid = 0; Wvalid = 0;
    chk("mr_rvalid", Rvalid, 1);
    chk("mr_bvalid", Bvalid, 1);
    resetn = 0;
    tick();
    chk("mr_rvalid0", Rvalid, 0);
    chk("mr_bvalid0", Bvalid, 0);
    chk("mr_rdata0", Rdata, 0);
    chk("mr_arready0", ARready, 0);
    chk("mr_wready0", Wready, 0);
    resetn = 1;
    tick();
    chk("mr_arready1", ARready, 1);
    chk("mr_awready1", AWready, 1);
    chk("mr_wready1", Wready, 1);
    rd(32'h34, 32'h77777777, 2'b00, 0);
    rd(32'h24, 32'hCAFEF00D, 2'b00, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_responder.md
AXI_LITE_MEM_RESPONDER -- requirements
Module: axi_lite_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, memory depth is 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte base address; SHALL be aligned to 4*2^DEPTH_LOG2.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 ARvalid  in  1  read address valid.
REQ-006 ARready  out  1  read address accept.
REQ-007 ARdata  in  32  read byte address.
REQ-008 arprot  in  3  read protection; ignored.
REQ-009 Rvalid  out  1  read data valid.
REQ-010 Rready  in  1  read data accept.
REQ-011 Rdata  out  32  full read word.
REQ-012 Rresp  out  2  00 OKAY, 10 SLVERR.
REQ-013 AWvalid  in  1  write address valid.
REQ-014 AWready  out  1  write address accept.
REQ-015 AWdata  in  32  write byte address.
REQ-016 awprot  in  3  write protection; ignored.
REQ-017 Wvalid  in  1  write data valid.
REQ-018 Wready  out  1  write data accept.
REQ-019 Wdata  in  32  write data, lane-replicated by the initiator.
REQ-020 Wstrb  in  4  byte enables; bit n covers Wdata[8n+7:8n].
REQ-021 Bvalid  out  1  write response valid.
REQ-022 Bready  in  1  write response accept.
REQ-023 Bresp  out  2  00 OKAY, 10 SLVERR.

Function
REQ-024 Handshake on a channel SHALL complete on any rising edge where valid and ready are both 1; once asserted, Rvalid/Bvalid and their payload SHALL hold until accepted.
REQ-025 Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored; in-range iff addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2].
REQ-026 Read FSM states R_IDLE, R_RESP; ARready = 1 only in R_IDLE.
REQ-027 AR handshake in R_IDLE -> next cycle R_RESP with Rvalid=1, Rdata = addressed word, Rresp=00 (out-of-range: Rdata=0, Rresp=10).
REQ-028 R_RESP -> R_IDLE on Rready=1; Rvalid deasserts same edge; next AR accepted earliest the cycle after.
REQ-029 Write FSM states W_COLLECT, W_RESP; in W_COLLECT AWready = !aw_held, Wready = !w_held; accepted AW address and W data/strobe registered independently, in either order or same cycle.
REQ-030 On the edge where both AW and W become held (captured or live), write SHALL commit: each byte with Wstrb[n]=1 updated, others unchanged; out-of-range write SHALL modify nothing.
REQ-031 Same edge -> W_RESP with Bvalid=1 next cycle, Bresp 00 (10 if out-of-range); held flags cleared.
REQ-032 W_RESP -> W_COLLECT on Bready=1; AWready/Wready stay 0 in W_RESP.
REQ-033 Wstrb=0000 write SHALL complete with Bresp=00 and no memory change.
REQ-034 Read and write channels SHALL operate concurrently; read capture and write commit to the same word on the same edge returns pre-write data (read-first).
REQ-035 Read latency: one cycle AR handshake to Rvalid; write latency: one cycle last of AW/W handshake to Bvalid.

Reset
REQ-036 resetn=0 at an edge: read FSM R_IDLE, write FSM W_COLLECT, held flags 0, Rvalid=0, Bvalid=0, Rdata=0, Rresp=00, Bresp=00; ARready/AWready/Wready forced 0 while resetn=0; memory contents not reset; reset mid-transaction abandons it silently.

Verification
REQ-037 AW 0x10 + W 0xDEADBEEF, Wstrb 1111, same cycle -> Bvalid next cycle, Bresp 00; then AR 0x10 -> Rvalid next cycle, Rdata 0xDEADBEEF.
REQ-038 Word 0x11223344 at 0x20; write Wdata 0xAAAAAAAA, Wstrb 0100 -> read returns 0x11AA3344.
REQ-039 W handshake 3 cycles before AW -> Wready 0 after W accepted, commit on AW edge, exactly one Bvalid pulse.
REQ-040 Rready held 0 for 5 cycles after Rvalid -> Rvalid/Rdata stable, ARready 0; same for Bready/Bvalid/Bresp.
REQ-041 AR and AW outside BASE_ADDR window -> Rdata 0, Rresp 10; Bresp 10; subsequent in-range read shows memory unchanged.
REQ-042 resetn low 1 cycle while Rvalid=1 and Bvalid=1 -> both 0 next cycle, ARready/AWready/Wready 1 cycle after release, memory retains data.
